// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
//   Player-input front end for arcade cores. Merges PS/2 keyboard key state
//   with per-player joystick words. Applies upright/cocktail merging and
//   opposite-direction cleanup, and shapes coin presses into fixed-length
//   pulses. Outputs registered, active-low bytes for the game core.
//
// Ports
//   clk_sys  system clock
//   reset_n  asynchronous active-low reset
//   ps2_key  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//   joy      per player p at [16p+15:16p]:
//            [0]R [1]L [2]D [3]U [4+i] trig i, [4+NBTN] start, [5+NBTN] coin
//   cabinet  0 = upright (all players' sticks/triggers OR'd into player 1),
//            1 = cocktail
//   af_mask  per-trigger autofire enable (only with AUTOFIRE_EN)
//   inp      per player, active-low: [7]L [6]R [5]U [4]D [3:0] trigs
//   sys      active-low: [3:0] shaped coin per player, [7:4] start per player
//
// Optional feature: define AUTOFIRE_EN to add af_mask and a shared autofire
// phase generator with a half-period of AF_CYC cycles.
module arcade_input_mapper #(
  parameter int          NPLAYERS = 2,
  parameter int          NBTN     = 3,
  parameter logic [23:0] COIN_CYC = 24'd4800000,
  parameter logic [23:0] AF_CYC   = 24'd2400000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [10:0]           ps2_key,
  input  logic [NPLAYERS*16-1:0] joy,
  input  logic                  cabinet,
`ifdef AUTOFIRE_EN
  input  logic [NBTN-1:0]       af_mask,
`endif
  output logic [NPLAYERS*8-1:0] inp,
  output logic [7:0]            sys
);

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_HOLD  = 2'd2
  } coin_state_e;

  // Key-state word per player: [0]R [1]L [2]D [3]U [7:4] trig0..3 [8] start [9] coin
  logic                         old_tog_r;
  logic [NPLAYERS-1:0][9:0]     key_r;
  logic                         key_evt_s;
  logic                         map_hit_s;
  logic [1:0]                   map_pl_s;
  logic [3:0]                   map_bit_s;

  logic [NPLAYERS-1:0][3:0]     dir_raw_s;
  logic [NPLAYERS-1:0][3:0]     trg_raw_s;
  logic [NPLAYERS-1:0][3:0]     dir_m_s;
  logic [NPLAYERS-1:0][3:0]     trg_m_s;
  logic [NPLAYERS-1:0]          start_raw_s;
  logic [NPLAYERS-1:0]          coin_raw_s;

  coin_state_e                  coin_st_r   [NPLAYERS];
  coin_state_e                  coin_st_nx_s[NPLAYERS];
  logic [23:0]                  coin_cnt_r   [NPLAYERS];
  logic [23:0]                  coin_cnt_nx_s[NPLAYERS];

  logic [NPLAYERS*8-1:0]        inp_nx_s;
  logic [7:0]                   sys_nx_s;
  logic [NPLAYERS*8-1:0]        inp_r;
  logic [7:0]                   sys_r;
  logic                         af_phase_s;

  // Joystick bits above the coin bit and keyboard triggers beyond NBTN carry no meaning.
  logic unused_s;
  assign unused_s  = ^{joy, key_r};

  assign key_evt_s = ps2_key[10] ^ old_tog_r;

  // Scancode decoder: arrows ignore the extended flag, every other key needs it clear.
  always_comb begin
    map_hit_s = 1'b0;
    map_pl_s  = 2'd0;
    map_bit_s = 4'd0;
    case (ps2_key[7:0])
      8'h74: begin map_hit_s = 1'b1;         map_bit_s = 4'd0; end
      8'h6B: begin map_hit_s = 1'b1;         map_bit_s = 4'd1; end
      8'h72: begin map_hit_s = 1'b1;         map_bit_s = 4'd2; end
      8'h75: begin map_hit_s = 1'b1;         map_bit_s = 4'd3; end
      8'h29: begin map_hit_s = ~ps2_key[8];  map_bit_s = 4'd4; end
      8'h14: begin map_hit_s = ~ps2_key[8];  map_bit_s = 4'd5; end
      8'h11: begin map_hit_s = ~ps2_key[8];  map_bit_s = 4'd6; end
      8'h12: begin map_hit_s = ~ps2_key[8];  map_bit_s = 4'd7; end
      8'h16: begin map_hit_s = ~ps2_key[8];  map_bit_s = 4'd8; end
      8'h2E: begin map_hit_s = ~ps2_key[8];  map_bit_s = 4'd9; end
      8'h34: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd1; map_bit_s = 4'd0; end
      8'h23: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd1; map_bit_s = 4'd1; end
      8'h2B: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd1; map_bit_s = 4'd2; end
      8'h2D: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd1; map_bit_s = 4'd3; end
      8'h1C: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd1; map_bit_s = 4'd4; end
      8'h1B: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd1; map_bit_s = 4'd5; end
      8'h15: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd1; map_bit_s = 4'd6; end
      8'h1D: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd1; map_bit_s = 4'd7; end
      8'h1E: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd1; map_bit_s = 4'd8; end
      8'h36: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd1; map_bit_s = 4'd9; end
      8'h26: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd2; map_bit_s = 4'd8; end
      8'h3D: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd2; map_bit_s = 4'd9; end
      8'h25: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd3; map_bit_s = 4'd8; end
      8'h3E: begin map_hit_s = ~ps2_key[8];  map_pl_s = 2'd3; map_bit_s = 4'd9; end
      default: begin map_hit_s = 1'b0; end
    endcase
  end

  // Key-state registers; keys for players that do not exist are dropped.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_tog_r <= 1'b0;
      key_r     <= '0;
    end else begin
      old_tog_r <= ps2_key[10];
      if (key_evt_s && map_hit_s) begin
        for (int p = 0; p < NPLAYERS; p++) begin
          if (map_pl_s == p[1:0]) begin
            key_r[p][map_bit_s] <= ps2_key[9];
          end
        end
      end
    end
  end

`ifdef AUTOFIRE_EN
  logic [23:0] af_cnt_r;
  logic        af_phase_r;

  // Shared autofire phase: flips once every AF_CYC cycles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt_r   <= 24'd0;
      af_phase_r <= 1'b0;
    end else if (af_cnt_r == AF_CYC - 24'd1) begin
      af_cnt_r   <= 24'd0;
      af_phase_r <= ~af_phase_r;
    end else begin
      af_cnt_r   <= af_cnt_r + 24'd1;
    end
  end

  assign af_phase_s = af_phase_r;
`else
  assign af_phase_s = 1'b1;
`endif

  // Raw per-player controls (keys OR joystick), cabinet merge and opposite-direction cleanup.
  always_comb begin
    dir_raw_s   = '0;
    trg_raw_s   = '0;
    start_raw_s = '0;
    coin_raw_s  = '0;
    for (int p = 0; p < NPLAYERS; p++) begin
      dir_raw_s[p]   = key_r[p][3:0] | joy[16*p +: 4];
      start_raw_s[p] = key_r[p][8] | joy[16*p + 4 + NBTN];
      coin_raw_s[p]  = key_r[p][9] | joy[16*p + 5 + NBTN];
      for (int i = 0; i < NBTN; i++) begin
        trg_raw_s[p][i] = key_r[p][4+i] | joy[16*p + 4 + i];
`ifdef AUTOFIRE_EN
        if (af_mask[i]) begin
          trg_raw_s[p][i] = trg_raw_s[p][i] & af_phase_s;
        end else begin
          trg_raw_s[p][i] = trg_raw_s[p][i];
        end
`endif
      end
    end

    dir_m_s = dir_raw_s;
    trg_m_s = trg_raw_s;
    if (!cabinet) begin
      for (int p = 1; p < NPLAYERS; p++) begin
        dir_m_s[0] = dir_m_s[0] | dir_raw_s[p];
        trg_m_s[0] = trg_m_s[0] | trg_raw_s[p];
      end
    end else begin
      dir_m_s[0] = dir_raw_s[0];
    end

    inp_nx_s = '1;
    for (int p = 0; p < NPLAYERS; p++) begin
      if (dir_m_s[p][0] && dir_m_s[p][1]) begin
        dir_m_s[p][1:0] = 2'b00;
      end else begin
        dir_m_s[p][1:0] = dir_m_s[p][1:0];
      end
      if (dir_m_s[p][2] && dir_m_s[p][3]) begin
        dir_m_s[p][3:2] = 2'b00;
      end else begin
        dir_m_s[p][3:2] = dir_m_s[p][3:2];
      end
      inp_nx_s[8*p +: 8] = ~{dir_m_s[p][1], dir_m_s[p][0], dir_m_s[p][3],
                             dir_m_s[p][2], trg_m_s[p]};
    end
  end

  // Coin pulse shaper next state: one fixed-length pulse per press, extra presses ignored.
  always_comb begin
    sys_nx_s = 8'hFF;
    for (int p = 0; p < NPLAYERS; p++) begin
      coin_st_nx_s[p]  = coin_st_r[p];
      coin_cnt_nx_s[p] = coin_cnt_r[p];
      case (coin_st_r[p])
        COIN_IDLE: begin
          if (coin_raw_s[p]) begin
            coin_st_nx_s[p]  = COIN_PULSE;
            coin_cnt_nx_s[p] = COIN_CYC - 24'd1;
          end else begin
            coin_st_nx_s[p]  = COIN_IDLE;
          end
        end
        COIN_PULSE: begin
          if (coin_cnt_r[p] == 24'd0) begin
            coin_st_nx_s[p]  = coin_raw_s[p] ? COIN_HOLD : COIN_IDLE;
          end else begin
            coin_cnt_nx_s[p] = coin_cnt_r[p] - 24'd1;
          end
        end
        COIN_HOLD: begin
          if (!coin_raw_s[p]) begin
            coin_st_nx_s[p] = COIN_IDLE;
          end else begin
            coin_st_nx_s[p] = COIN_HOLD;
          end
        end
        default: begin
          coin_st_nx_s[p]  = COIN_IDLE;
          coin_cnt_nx_s[p] = 24'd0;
        end
      endcase
      // Output register mirrors the next state so the pulse starts one clock after the press.
      sys_nx_s[p]   = (coin_st_nx_s[p] != COIN_PULSE);
      sys_nx_s[4+p] = ~start_raw_s[p];
    end
  end

  // Coin state registers and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPLAYERS; p++) begin
        coin_st_r[p]  <= COIN_IDLE;
        coin_cnt_r[p] <= 24'd0;
      end
      inp_r <= '1;
      sys_r <= 8'hFF;
    end else begin
      for (int p = 0; p < NPLAYERS; p++) begin
        coin_st_r[p]  <= coin_st_nx_s[p];
        coin_cnt_r[p] <= coin_cnt_nx_s[p];
      end
      inp_r <= inp_nx_s;
      sys_r <= sys_nx_s;
    end
  end

  assign inp = inp_r;
  assign sys = sys_r;

endmodule

// File: tb/tb_arcade_input_mapper.sv
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] joy;
  logic        cabinet;
  logic [15:0] inp;
  logic [7:0]  sys;
`ifdef AUTOFIRE_EN
  logic [2:0]  af_mask;
`endif

  int   total = 0;
  int   bad   = 0;
  logic tog   = 1'b0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(
    .NPLAYERS(2),
    .NBTN    (3),
    .COIN_CYC(24'd8),
    .AF_CYC  (24'd4)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_key(ps2_key),
    .joy    (joy),
    .cabinet(cabinet),
`ifdef AUTOFIRE_EN
    .af_mask(af_mask),
`endif
    .inp    (inp),
    .sys    (sys)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic key_evt(input logic pressed, input logic ext, input logic [7:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, ext, code};
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ps2_key = 11'd0; joy = 32'd0; cabinet = 1'b1; tog = 1'b0;
`ifdef AUTOFIRE_EN
    af_mask = 3'b000;
`endif
    #12;
    total++; if (inp !== 16'hFFFF) begin bad++; $display("FAIL reset_inp: got %h want ffff", inp); end
    total++; if (sys !== 8'hFF) begin bad++; $display("FAIL reset_sys: got %h want ff", sys); end
    tick(1); reset_n = 1'b1; tick(2);
    total++; if (inp !== 16'hFFFF) begin bad++; $display("FAIL idle_inp: got %h want ffff", inp); end
    total++; if (sys !== 8'hFF) begin bad++; $display("FAIL idle_sys: got %h want ff", sys); end
  endtask

  task automatic test_ps2;
    key_evt(1'b1, 1'b0, 8'h75);
    tick(1);
    total++; if (inp !== 16'hFFFF) begin bad++; $display("FAIL ps2_up_early: got %h want ffff", inp); end
    tick(1);
    total++; if (inp !== 16'hFFDF) begin bad++; $display("FAIL ps2_up_press: got %h want ffdf", inp); end
    key_evt(1'b0, 1'b0, 8'h75); tick(2);
    total++; if (inp !== 16'hFFFF) begin bad++; $display("FAIL ps2_up_release: got %h want ffff", inp); end
    key_evt(1'b1, 1'b1, 8'h72); tick(2);
    total++; if (inp !== 16'hFFEF) begin bad++; $display("FAIL ps2_ext_down: got %h want ffef", inp); end
    key_evt(1'b0, 1'b1, 8'h72); tick(2);
    key_evt(1'b1, 1'b1, 8'h16); tick(2);
    total++; if (sys !== 8'hFF) begin bad++; $display("FAIL ps2_ext_start_ignored: got %h want ff", sys); end
    key_evt(1'b1, 1'b0, 8'h16); tick(2);
    total++; if (sys !== 8'hEF) begin bad++; $display("FAIL ps2_start1: got %h want ef", sys); end
    key_evt(1'b0, 1'b0, 8'h16); tick(2);
    key_evt(1'b1, 1'b0, 8'h1C); tick(2);
    total++; if (inp !== 16'hFEFF) begin bad++; $display("FAIL ps2_p2_trig0: got %h want feff", inp); end
    // Changing pressed without flipping the toggle is not an event.
    ps2_key = {tog, 1'b0, 1'b0, 8'h1C}; tick(3);
    total++; if (inp !== 16'hFEFF) begin bad++; $display("FAIL ps2_no_toggle: got %h want feff", inp); end
    key_evt(1'b0, 1'b0, 8'h1C); tick(2);
    total++; if (inp !== 16'hFFFF) begin bad++; $display("FAIL ps2_p2_release: got %h want ffff", inp); end
  endtask

  task automatic test_upright;
    cabinet = 1'b0; joy = 32'h0010_0000; tick(1);
    total++; if (inp !== 16'hFEFE) begin bad++; $display("FAIL upright_trig: got %h want fefe", inp); end
    cabinet = 1'b1; tick(1);
    total++; if (inp !== 16'hFEFF) begin bad++; $display("FAIL cocktail_trig: got %h want feff", inp); end
    cabinet = 1'b0; joy = 32'h0008_0000; tick(1);
    total++; if (inp !== 16'hDFDF) begin bad++; $display("FAIL upright_up: got %h want dfdf", inp); end
    joy = 32'h0002_0001; tick(1);
    total++; if (inp !== 16'h7FFF) begin bad++; $display("FAIL upright_merge_cleanup: got %h want 7fff", inp); end
    joy = 32'h0080_0000; tick(1);
    total++; if (sys !== 8'hDF || inp !== 16'hFFFF) begin bad++; $display("FAIL upright_start_unmerged: got %h/%h want df/ffff", sys, inp); end
    cabinet = 1'b1; joy = 32'd0; tick(1);
  endtask

  task automatic test_opposite;
    joy = 32'h0000_0003; tick(1);
    total++; if (inp[7:6] !== 2'b11) begin bad++; $display("FAIL opp_lr: got %b want 11", inp[7:6]); end
    joy = 32'h0000_0001; tick(1);
    total++; if (inp !== 16'hFFBF) begin bad++; $display("FAIL opp_r_only: got %h want ffbf", inp); end
    joy = 32'h0000_000C; tick(1);
    total++; if (inp !== 16'hFFFF) begin bad++; $display("FAIL opp_ud: got %h want ffff", inp); end
    joy = 32'h0000_0044; tick(1);
    total++; if (inp !== 16'hFFEB) begin bad++; $display("FAIL trig2_down: got %h want ffeb", inp); end
    joy = 32'h0000_0080; tick(1);
    total++; if (sys !== 8'hEF || inp !== 16'hFFFF) begin bad++; $display("FAIL joy_start1: got %h/%h want ef/ffff", sys, inp); end
    joy = 32'd0; tick(1);
  endtask

  task automatic test_coin;
    int lows;
    int falls;
    logic prev;
    // Held 20 clocks: exactly 8 low, high at the end while still held.
    joy = 32'h0000_0100; lows = 0;
    for (int k = 0; k < 20; k++) begin tick(1); if (sys[0] === 1'b0) lows++; end
    total++; if (lows != 8) begin bad++; $display("FAIL coin_hold_len: got %0d want 8", lows); end
    total++; if (sys[0] !== 1'b1) begin bad++; $display("FAIL coin_hold_end: got %b want 1", sys[0]); end
    joy = 32'd0; tick(1);
    total++; if (sys !== 8'hFF) begin bad++; $display("FAIL coin_released: got %h want ff", sys); end
    // Re-press: new pulse, first low on the first clock.
    joy = 32'h0000_0100; tick(1);
    total++; if (sys[0] !== 1'b0) begin bad++; $display("FAIL coin_repress_start: got %b want 0", sys[0]); end
    lows = 1;
    for (int k = 0; k < 11; k++) begin tick(1); if (sys[0] === 1'b0) lows++; end
    total++; if (lows != 8) begin bad++; $display("FAIL coin_repress_len: got %0d want 8", lows); end
    joy = 32'd0; tick(2);
    // Press, release, press within the pulse: one pulse only.
    lows = 0; falls = 0; prev = sys[0];
    for (int k = 0; k < 20; k++) begin
      if (k == 0) joy = 32'h0000_0100;
      else if (k == 2) joy = 32'd0;
      else if (k == 4) joy = 32'h0000_0100;
      else if (k == 14) joy = 32'd0;
      tick(1);
      if (sys[0] === 1'b0) lows++;
      if (prev === 1'b1 && sys[0] === 1'b0) falls++;
      prev = sys[0];
    end
    total++; if (lows != 8 || falls != 1) begin bad++; $display("FAIL coin_bounce: got lows=%0d pulses=%0d want 8/1", lows, falls); end
    // Player 2 coin from keyboard '6': two clocks to first low.
    key_evt(1'b1, 1'b0, 8'h36); tick(1);
    total++; if (sys[1] !== 1'b1) begin bad++; $display("FAIL coin_p2_early: got %b want 1", sys[1]); end
    lows = 0;
    for (int k = 0; k < 12; k++) begin tick(1); if (sys[1] === 1'b0) lows++; end
    total++; if (lows != 8 || sys[0] !== 1'b1) begin bad++; $display("FAIL coin_p2_key_len: got %0d/%b want 8/1", lows, sys[0]); end
    key_evt(1'b0, 1'b0, 8'h36); tick(2);
  endtask

  task automatic test_reset_mid_pulse;
    joy = 32'h0000_0100; tick(3);
    total++; if (sys[0] !== 1'b0) begin bad++; $display("FAIL mid_pulse_active: got %b want 0", sys[0]); end
    #2 reset_n = 1'b0; #1;
    total++; if (sys !== 8'hFF) begin bad++; $display("FAIL reset_mid_pulse: got %h want ff", sys); end
    joy = 32'd0; ps2_key = 11'd0; tog = 1'b0;
    tick(1); reset_n = 1'b1; tick(3);
    total++; if (sys !== 8'hFF) begin bad++; $display("FAIL after_reset_idle: got %h want ff", sys); end
  endtask

`ifdef AUTOFIRE_EN
  task automatic test_autofire;
    logic v [24];
    int changes;
    af_mask = 3'b001; joy = 32'h0000_0010;
    for (int k = 0; k < 24; k++) begin tick(1); v[k] = inp[0]; end
    for (int k = 0; k < 20; k++) begin
      total++; if (v[k] === v[k+4]) begin bad++; $display("FAIL af_toggle_%0d: got %b want %b", k, v[k+4], ~v[k]); end
    end
    changes = 0;
    for (int k = 1; k < 24; k++) if (v[k] !== v[k-1]) changes++;
    total++; if (changes < 5 || changes > 6) begin bad++; $display("FAIL af_changes: got %0d want 5..6", changes); end
    af_mask = 3'b000; changes = 0;
    for (int k = 0; k < 10; k++) begin tick(1); if (k > 0 && inp[0] !== 1'b0) changes++; end
    total++; if (changes != 0) begin bad++; $display("FAIL af_mask_off: got %0d high samples want 0", changes); end
    joy = 32'd0; tick(1);
  endtask
`endif

  initial begin
    test_reset();
    test_ps2();
    test_upright();
    test_opposite();
    test_coin();
`ifdef AUTOFIRE_EN
    test_autofire();
`endif
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
